// File: rtl/core_mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one shared memory port.
// One transaction in flight; data wins ties except when its contested-win streak forces a fetch.
module core_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_grnt_o,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_wen_i,
  output logic              data_grnt_o,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_req_o,
  input  logic              mem_grnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_valid_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_data_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              wen_r;
  logic [3:0]        streak_r;

  logic any_req_s;
  logic both_req_s;
  logic pick_data_s;
  logic fire_grnt_s;
  logic fire_valid_s;

  assign any_req_s   = inst_req_i | data_req_i;
  assign both_req_s  = inst_req_i & data_req_i;
  // Data wins unless a fetch is also waiting and data has used up its streak.
  assign pick_data_s = data_req_i & (~inst_req_i | (streak_r != STREAK_MAX));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_req_s   ? REQ  : IDLE;
      REQ:     state_nxt_s = mem_grnt_i  ? RESP : REQ;
      RESP:    state_nxt_s = mem_valid_i ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction latch and starvation streak, updated only when a new transaction is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_data_r <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      wen_r        <= 1'b0;
      streak_r     <= 4'd0;
    end else if ((state_r == IDLE) && any_req_s) begin
      owner_data_r <= pick_data_s;
      addr_r       <= pick_data_s ? data_addr_i : inst_addr_i;
      wdata_r      <= pick_data_s ? data_wdata_i : '0;
      wen_r        <= pick_data_s & data_wen_i;
      if (!pick_data_s) begin
        streak_r <= 4'd0;
      end else if (both_req_s) begin
        streak_r <= streak_r + 4'd1;
      end else begin
        streak_r <= streak_r;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

  // Pulses are suppressed while reset is asserted so an abandoned transaction never completes.
  assign fire_grnt_s  = (state_r == REQ)  & mem_grnt_i  & ~rst_i;
  assign fire_valid_s = (state_r == RESP) & mem_valid_i & ~rst_i;

  // Output decode.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wen_o    = 1'b0;
    case (state_r)
      REQ: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = addr_r;
        mem_wdata_o = wdata_r;
        mem_wen_o   = wen_r;
      end
      IDLE:    mem_req_o = 1'b0;
      RESP:    mem_req_o = 1'b0;
      default: mem_req_o = 1'b0;
    endcase
    inst_grnt_o  = fire_grnt_s  & ~owner_data_r;
    data_grnt_o  = fire_grnt_s  &  owner_data_r;
    inst_valid_o = fire_valid_s & ~owner_data_r;
    data_valid_o = fire_valid_s &  owner_data_r;
    inst_data_o  = inst_valid_o ? mem_rdata_i : '0;
    data_rdata_o = data_valid_o ? mem_rdata_i : '0;
    busy_o       = (state_r != IDLE);
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter; inputs change just after the rising
// edge and outputs are compared mid-cycle.
module tb_core_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_grnt_o;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_data_o;
  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_wen_i;
  logic              data_grnt_o;
  logic              data_valid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              mem_req_o;
  logic              mem_grnt_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_wen_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_valid_i;
  logic              busy_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  core_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_grnt_o(inst_grnt_o),
    .inst_valid_o(inst_valid_o), .inst_data_o(inst_data_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_wen_i(data_wen_i), .data_grnt_o(data_grnt_o), .data_valid_o(data_valid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_grnt_i(mem_grnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata_i),
    .mem_valid_i(mem_valid_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [9:0] exp_d;

  initial begin
    rst_i = 1'b1; inst_req_i = 1'b0; inst_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_wen_i = 1'b0;
    mem_grnt_i = 1'b0; mem_rdata_i = '0; mem_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; #1;
    check("rst_busy", busy_o, 32'd0);
    check("rst_mem_req", mem_req_o, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_igrnt", inst_grnt_o, 32'd0);

    // Single fetch, immediate grant, data one cycle later.
    inst_req_i = 1'b1; inst_addr_i = 32'h100; #1;
    check("f_idle_igrnt", inst_grnt_o, 32'd0);
    tick(); mem_grnt_i = 1'b1; #1;
    check("f_busy", busy_o, 32'd1);
    check("f_mem_req", mem_req_o, 32'd1);
    check("f_mem_addr", mem_addr_o, 32'h100);
    check("f_mem_wen", mem_wen_o, 32'd0);
    check("f_igrnt", inst_grnt_o, 32'd1);
    check("f_dgrnt", data_grnt_o, 32'd0);
    tick(); inst_req_i = 1'b0; mem_grnt_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
    check("f_ivalid", inst_valid_o, 32'd1);
    check("f_idata", inst_data_o, 32'hDEADBEEF);
    check("f_dvalid", data_valid_o, 32'd0);
    check("f_drdata", data_rdata_o, 32'd0);
    check("f_resp_req", mem_req_o, 32'd0);
    tick(); mem_valid_i = 1'b0; #1;
    check("f_done_busy", busy_o, 32'd0);
    check("f_done_idata", inst_data_o, 32'd0);

    // Store held over three stalled-grant cycles; inputs change but must not be re-sampled.
    data_req_i = 1'b1; data_addr_i = 32'h40; data_wdata_i = 32'h12345678; data_wen_i = 1'b1; #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_valid_i = (k == 1);
      data_addr_i = 32'hFFF;
      data_wdata_i = 32'h0BADF00D;
      #1;
      check("s_stall_req", mem_req_o, 32'd1);
      check("s_stall_wen", mem_wen_o, 32'd1);
      check("s_stall_addr", mem_addr_o, 32'h40);
      check("s_stall_wdata", mem_wdata_o, 32'h12345678);
      check("s_stall_dgrnt", data_grnt_o, 32'd0);
      check("s_stall_dvalid", data_valid_o, 32'd0);
      tick();
    end
    mem_valid_i = 1'b0; mem_grnt_i = 1'b1; #1;
    check("s_dgrnt", data_grnt_o, 32'd1);
    check("s_igrnt", inst_grnt_o, 32'd0);
    tick(); data_req_i = 1'b0; data_wen_i = 1'b0; mem_grnt_i = 1'b0; #1;
    check("s_resp_req", mem_req_o, 32'd0);
    check("s_resp_wdata", mem_wdata_o, 32'd0);
    check("s_resp_wen", mem_wen_o, 32'd0);
    check("s_resp_wait", data_valid_o, 32'd0);
    check("s_resp_busy", busy_o, 32'd1);
    tick(); mem_valid_i = 1'b1; mem_rdata_i = 32'h0000A5A5; #1;
    check("s_dvalid", data_valid_o, 32'd1);
    check("s_drdata", data_rdata_o, 32'h0000A5A5);
    check("s_ivalid", inst_valid_o, 32'd0);
    check("s_idata", inst_data_o, 32'd0);
    tick(); mem_valid_i = 1'b0; #1;
    check("s_done_busy", busy_o, 32'd0);

    // Both requesting continuously: expected order D,D,D,D,I,D,D,D,D,I (bit i = 1 for data).
    exp_d = 10'b0111101111;
    inst_req_i = 1'b1; inst_addr_i = 32'h200;
    data_req_i = 1'b1; data_addr_i = 32'h300; data_wen_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; tick();
      mem_grnt_i = 1'b1; #1;
      check("arb_dgrnt", data_grnt_o, {31'd0, exp_d[i]});
      check("arb_igrnt", inst_grnt_o, {31'd0, ~exp_d[i]});
      check("arb_addr", mem_addr_o, exp_d[i] ? 32'h300 : 32'h200);
      tick(); mem_grnt_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'h1000 + i; #1;
      check("arb_dvalid", data_valid_o, {31'd0, exp_d[i]});
      tick(); mem_valid_i = 1'b0;
    end
    inst_req_i = 1'b0; data_req_i = 1'b0; #1;

    // Reset during RESP abandons the fetch; a later response is ignored.
    inst_req_i = 1'b1; inst_addr_i = 32'h400; #1;
    tick(); mem_grnt_i = 1'b1; #1;
    tick(); inst_req_i = 1'b0; mem_grnt_i = 1'b0; rst_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'h5555; #1;
    check("r_resp_ivalid", inst_valid_o, 32'd0);
    tick(); rst_i = 1'b0; #1;
    check("r_after_ivalid", inst_valid_o, 32'd0);
    check("r_after_idata", inst_data_o, 32'd0);
    check("r_after_busy", busy_o, 32'd0);
    check("r_after_req", mem_req_o, 32'd0);
    tick(); mem_valid_i = 1'b0;

    // Reset during REQ suppresses the grant pulse.
    data_req_i = 1'b1; data_addr_i = 32'h500; #1;
    tick(); rst_i = 1'b1; mem_grnt_i = 1'b1; #1;
    check("rq_rst_dgrnt", data_grnt_o, 32'd0);
    tick(); rst_i = 1'b0; data_req_i = 1'b0; #1;
    check("rq_after_busy", busy_o, 32'd0);
    check("rq_after_dgrnt", data_grnt_o, 32'd0);
    check("rq_after_req", mem_req_o, 32'd0);
    tick(); mem_grnt_i = 1'b0;

    // Spurious memory handshakes while idle.
    mem_grnt_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'h7777;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("sp_busy", busy_o, 32'd0);
      check("sp_grnt", {31'd0, inst_grnt_o | data_grnt_o}, 32'd0);
      check("sp_valid", {31'd0, inst_valid_o | data_valid_o}, 32'd0);
      check("sp_drdata", data_rdata_o, 32'd0);
      tick();
    end
    mem_grnt_i = 1'b0; mem_valid_i = 1'b0;

    // Normal load still works afterwards.
    data_req_i = 1'b1; data_addr_i = 32'h60; data_wen_i = 1'b0; #1;
    tick(); mem_grnt_i = 1'b1; #1;
    check("l_dgrnt", data_grnt_o, 32'd1);
    check("l_addr", mem_addr_o, 32'h60);
    check("l_wen", mem_wen_o, 32'd0);
    tick(); data_req_i = 1'b0; mem_grnt_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
    check("l_dvalid", data_valid_o, 32'd1);
    check("l_drdata", data_rdata_o, 32'hCAFEF00D);
    tick(); mem_valid_i = 1'b0; #1;
    check("l_done_busy", busy_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
